// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, stall hold and prioritised redirects with a pending slot.
// Optional performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h00000C00,
    parameter logic [29:0] EXC_PC   = 30'h00001060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ready,
    input  logic        id_stall,
    input  logic        redir_valid,
    input  logic [29:0] redir_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [29:0] epc,
    output logic [29:0] pc,
    output logic        pc_valid,
    output logic        flush_if,
    output logic        redir_pend
`ifdef PC_SEQ_PERF_EN
   ,output logic [31:0] perf_redir,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned PC_W  = 30;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        PEND   = 2'd2,
        BUBBLE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              flush_if_q, flush_if_d;
    logic              redir_pend_q, redir_pend_d;
    logic              src_valid;
    logic [PC_W-1:0]   src_pc;

    // Highest-priority redirect source; only exceptions are accepted during the bubble.
    always_comb begin
        src_valid = exc_req;
        if (state_q != BUBBLE) begin
            src_valid = exc_req | eret_req | redir_valid;
        end
        if (exc_req) begin
            src_pc = EXC_PC;
        end else if (eret_req) begin
            src_pc = epc;
        end else begin
            src_pc = redir_pc;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        flush_if_d = 1'b0;
        case (state_q)
            RUN, HOLD: begin
                if (src_valid) begin
                    if (if_ready) begin
                        pc_d       = src_pc;
                        flush_if_d = 1'b1;
                        state_d    = BUBBLE;
                    end else begin
                        pend_pc_d  = src_pc;
                        state_d    = PEND;
                    end
                end else if (id_stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    if (if_ready) begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            PEND: begin
                // A late exception supersedes the captured target; other sources are dropped.
                if (if_ready) begin
                    pc_d       = exc_req ? EXC_PC : pend_pc_q;
                    flush_if_d = 1'b1;
                    state_d    = BUBBLE;
                end else if (exc_req) begin
                    pend_pc_d = EXC_PC;
                end
            end
            BUBBLE: begin
                if (src_valid) begin
                    if (if_ready) begin
                        pc_d       = src_pc;
                        flush_if_d = 1'b1;
                        state_d    = BUBBLE;
                    end else begin
                        pend_pc_d  = src_pc;
                        state_d    = PEND;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BUBBLE;
        endcase
        pc_valid_d   = (state_d != BUBBLE);
        redir_pend_d = (state_d == PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BUBBLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pc_valid_q   <= 1'b0;
            flush_if_q   <= 1'b0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pc_valid_q   <= pc_valid_d;
            flush_if_q   <= flush_if_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign flush_if   = flush_if_q;
    assign redir_pend = redir_pend_q;

`ifdef PC_SEQ_PERF_EN
    logic [CNT_W-1:0] perf_redir_q, perf_redir_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

    // Saturating counters: accepted redirects at the load edge, and held cycles.
    always_comb begin
        perf_redir_d = perf_redir_q;
        perf_stall_d = perf_stall_q;
        if (flush_if_d && (perf_redir_q != {CNT_W{1'b1}})) begin
            perf_redir_d = perf_redir_q + CNT_W'(1);
        end
        if (((state_q == HOLD) || (state_q == PEND)) && (perf_stall_q != {CNT_W{1'b1}})) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redir_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_redir_q <= perf_redir_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_redir = perf_redir_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes predicted outputs, monitor pops and compares.
module tb_pc_sequencer;

    localparam logic [29:0] RST_PC = 30'h00000C00;
    localparam logic [29:0] EXC    = 30'h00001060;

    logic        clk = 1'b0;
    logic        rst, if_ready, id_stall, redir_valid, exc_req, eret_req;
    logic [29:0] redir_pc, epc;
    logic [29:0] pc;
    logic        pc_valid, flush_if, redir_pend;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_redir, perf_stall;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .if_ready   (if_ready),
        .id_stall   (id_stall),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush_if   (flush_if),
        .redir_pend (redir_pend)
`ifdef PC_SEQ_PERF_EN
       ,.perf_redir (perf_redir),
        .perf_stall (perf_stall)
`endif
    );

    typedef struct {
        logic [29:0] pc;
        logic        valid;
        logic        flush;
        logic        pend;
        logic [31:0] n_redir;
        logic [31:0] n_stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: what the fetch front end is doing, in plain terms.
    bit          m_bubble;     // current cycle is the non-fetch bubble
    bit          m_stalled;    // pc held because ID asked for it
    bit          m_waiting;    // a redirect target is parked until fetch accepts
    logic [29:0] m_pc, m_target;
    logic [31:0] m_redirs, m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one set of outputs is presented after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("pc_valid", 32'(pc_valid), 32'(e.valid));
                chk("flush_if", 32'(flush_if), 32'(e.flush));
                chk("redir_pend", 32'(redir_pend), 32'(e.pend));
`ifdef PC_SEQ_PERF_EN
                chk("perf_redir", perf_redir, e.n_redir);
                chk("perf_stall", perf_stall, e.n_stall);
`endif
            end
        end
    end

    task automatic step(input bit r, input bit rdy, input bit st, input bit rv,
                        input logic [29:0] rp, input bit ex, input bit er,
                        input logic [29:0] ep);
        exp_t        e;
        bit          want;
        logic [29:0] dest;
        @(negedge clk);
        rst = r; if_ready = rdy; id_stall = st; redir_valid = rv;
        redir_pc = rp; exc_req = ex; eret_req = er; epc = ep;
        e.flush = 1'b0;
        if (r) begin
            m_pc = RST_PC; m_bubble = 1; m_stalled = 0; m_waiting = 0;
            m_target = '0; m_redirs = 0; m_stalls = 0;
        end else begin
            if ((m_stalled || m_waiting) && m_stalls != 32'hFFFFFFFF) m_stalls++;
            if (m_waiting) begin
                if (ex) m_target = EXC;
                if (rdy) begin
                    m_pc = m_target; m_waiting = 0; m_bubble = 1; e.flush = 1'b1;
                end
            end else begin
                want = ex || (!m_bubble && (er || rv));
                dest = ex ? EXC : (er ? ep : rp);
                if (want) begin
                    m_stalled = 0;
                    if (rdy) begin
                        m_pc = dest; m_bubble = 1; e.flush = 1'b1;
                    end else begin
                        m_target = dest; m_waiting = 1; m_bubble = 0;
                    end
                end else if (m_bubble) begin
                    m_bubble = 0;
                end else if (st) begin
                    m_stalled = 1;
                end else begin
                    m_stalled = 0;
                    if (rdy) m_pc = m_pc + 30'd1;
                end
            end
            if (e.flush && m_redirs != 32'hFFFFFFFF) m_redirs++;
        end
        e.pc = m_pc; e.valid = !m_bubble; e.pend = m_waiting;
        e.n_redir = m_redirs; e.n_stall = m_stalls;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rdy);
        step(0, rdy, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic to_c05();
        step(1, 0, 0, 0, '0, 0, 0, '0);
        repeat (6) idle(1);
    endtask

    initial begin
        rst = 1; if_ready = 0; id_stall = 0; redir_valid = 0;
        redir_pc = '0; exc_req = 0; eret_req = 0; epc = '0;

        // Reset, release and sequential fetch, then redirect with fetch ready.
        step(1, 0, 0, 0, '0, 0, 0, '0);
        step(1, 1, 0, 0, '0, 0, 0, '0);
        repeat (6) idle(1);
        step(0, 1, 0, 1, 30'h0D00, 0, 0, '0);
        idle(0);
        idle(1);

        // Redirect parked while fetch is not ready.
        to_c05();
        step(0, 0, 0, 1, 30'h0D00, 0, 0, '0);
        idle(0);
        idle(0);
        idle(1);
        idle(1);

        // All three sources at once; then an exception replacing a parked target.
        to_c05();
        step(0, 1, 0, 1, 30'h0D00, 1, 1, 30'h0C40);
        idle(1);
        to_c05();
        step(0, 0, 0, 1, 30'h0D00, 0, 0, '0);
        step(0, 0, 0, 1, 30'h0D00, 1, 0, '0);
        step(0, 0, 0, 0, 30'h0D00, 0, 1, 30'h0C40);
        idle(1);
        idle(1);

        // Wrap-around, then a four-cycle stall.
        step(0, 1, 0, 1, 30'h3FFFFFFF, 0, 0, '0);
        idle(1);
        idle(1);
        idle(1);
        repeat (4) step(0, 1, 1, 0, '0, 0, 0, '0);
        idle(1);
        idle(1);

        // Reset in the middle of a parked redirect.
        to_c05();
        step(0, 0, 0, 1, 30'h0D00, 0, 0, '0);
        step(1, 1, 0, 0, '0, 0, 0, '0);
        repeat (3) idle(1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [29:0] rp, ep;
            rp = ($urandom_range(7) == 0) ? 30'h3FFFFFFE : 30'($urandom());
            ep = 30'($urandom());
            step($urandom_range(79) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
                 $urandom_range(7) == 0, rp, $urandom_range(15) == 0,
                 $urandom_range(11) == 0, ep);
        end

        repeat (5) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected responses never compared", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 30'h00000C00, is the word address (bits 31:2) loaded into pc on reset.
REQ-002 Parameter EXC_PC, default 30'h00001060, is the word address of the exception handler.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_ready  input  1  fetch stage accepts the current pc this cycle.
REQ-006 id_stall  input  1  hazard unit requests the pc be held.
REQ-007 redir_valid  input  1  ID resolved a taken branch, jump or jr.
REQ-008 redir_pc  input  30  target word address for redir_valid.
REQ-009 exc_req  input  1  exception detected; go to EXC_PC.
REQ-010 eret_req  input  1  eret executing; return to epc.
REQ-011 epc  input  30  exception return word address.
REQ-012 pc  output  30  current fetch word address.
REQ-013 pc_valid  output  1  pc is a fetch request; low during the reset cycle and the bubble cycle.
REQ-014 flush_if  output  1  squash the instruction currently in IF/ID.
REQ-015 redir_pend  output  1  a redirect is captured and waiting for if_ready.

Function
REQ-016 Redirect source priority SHALL be exc_req > eret_req > redir_valid; only the highest asserted source is taken.
REQ-017 Target SHALL be EXC_PC for exc_req, epc for eret_req and redir_pc for redir_valid.
REQ-018 States SHALL be RUN, HOLD, PEND and BUBBLE.
REQ-019 In RUN, with no redirect and no id_stall, pc SHALL become pc+1 (30-bit wrap-around, 30'h3FFFFFFF -> 0) at the edge where if_ready=1; otherwise pc SHALL hold.
REQ-020 In RUN, id_stall=1 with no redirect SHALL hold pc and enter HOLD; HOLD SHALL return to RUN in the first cycle with id_stall=0.
REQ-021 A redirect with if_ready=1 SHALL load the target into pc at the next edge, pulse flush_if for exactly that next cycle and enter BUBBLE; redirects SHALL override id_stall.
REQ-022 A redirect with if_ready=0 SHALL capture the target in a pending register, set redir_pend the next cycle and enter PEND.
REQ-023 In PEND, pc SHALL hold; on the first cycle with if_ready=1 the pending target SHALL be loaded at that edge, flush_if SHALL pulse, redir_pend SHALL clear and the state SHALL become BUBBLE.
REQ-024 In PEND, a new exc_req SHALL overwrite the pending target; a new eret_req or redir_valid SHALL be ignored.
REQ-025 BUBBLE SHALL last one cycle with pc_valid=0 and then enter RUN; exc_req in BUBBLE SHALL be taken as in RUN.
REQ-026 pc_valid SHALL be 1 in RUN, HOLD and PEND.

Reset
REQ-027 rst=1 SHALL set pc=RESET_PC, state=BUBBLE, pc_valid=0, flush_if=0, redir_pend=0, clear the pending register and clear the counters.
REQ-028 rst SHALL take precedence over all other inputs, including in mid-PEND; any captured target SHALL be discarded.

Configuration
REQ-029 With macro PC_SEQ_PERF_EN defined, the block SHALL add outputs perf_redir[31:0], counting accepted redirects (count at the load edge), and perf_stall[31:0], counting cycles in HOLD or PEND; both saturate at 32'hFFFFFFFF.
REQ-030 Without PC_SEQ_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-031 Reset, release, then if_ready=1 for 3 cycles -> pc_valid=0 for one cycle, then pc = C00, C01, C02, C03.
REQ-032 At pc=C05, redir_valid=1 with redir_pc=0x0D00 and if_ready=1 -> next cycle pc=D00, flush_if=1, pc_valid=0; the following cycle pc_valid=1 and pc=D00.
REQ-033 Same redirect with if_ready=0 for 3 cycles -> redir_pend=1, pc held at C05; when if_ready rises, pc=D00 at the next edge and redir_pend=0.
REQ-034 exc_req, eret_req (epc=0x0C40) and redir_valid asserted together -> pc=1060; during PEND an exc_req replaces a pending D00 with 1060.
REQ-035 pc=30'h3FFFFFFF with if_ready=1 -> pc=0; id_stall=1 for 4 cycles -> pc constant and, with PC_SEQ_PERF_EN, perf_stall increments by 4.
REQ-036 rst asserted while in PEND -> next cycle pc=C00, redir_pend=0, and the pending target is never loaded.
